// File: rtl/mms_pkg.sv
// Shared Sv32 walker types: PTE/VA layouts, PTE flag indices, walker states.
package mms_pkg;

    localparam int VPN_W   = 10;
    localparam int PPN_W   = 22;
    localparam int PGOFF_W = 12;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam logic [1:0] MODE_U = 2'b00;
    localparam logic [1:0] MODE_S = 2'b01;

    typedef struct packed {
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic [7:0]       flags;
    } pte_t;

    typedef struct packed {
        logic [VPN_W-1:0]   vpn1;
        logic [VPN_W-1:0]   vpn0;
        logic [PGOFF_W-1:0] offset;
    } va_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_REQ,
        ST_L1_WAIT,
        ST_L0_REQ,
        ST_L0_WAIT,
        ST_RESP
    } ptw_state_e;

endpackage

// File: rtl/itlb_ptw_pte_check.sv
// Combinational instruction-fetch PTE check: classifies a PTE as descend, leaf or page fault.
module itlb_ptw_pte_check
    import mms_pkg::*;
(
    input  pte_t       pte,
    input  logic       level,
    input  logic [1:0] mode,
    output logic       descend,
    output logic       leaf,
    output logic       pf
);

    logic v, r, w, x, u, a;

    assign v = pte.flags[PTE_V];
    assign r = pte.flags[PTE_R];
    assign w = pte.flags[PTE_W];
    assign x = pte.flags[PTE_X];
    assign u = pte.flags[PTE_U];
    assign a = pte.flags[PTE_A];

    // level=1 is the root (L1) table; the first matching rule decides.
    always_comb begin
        descend = 1'b0;
        leaf    = 1'b0;
        pf      = 1'b0;
        if (!v || (!r && w)) begin
            pf = 1'b1;
        end else if (!r && !x) begin
            if (level) descend = 1'b1;
            else       pf      = 1'b1;
        end else if (!x || !a) begin
            pf = 1'b1;
        end else if ((mode == MODE_U) && !u) begin
            pf = 1'b1;
        end else if ((mode == MODE_S) && u) begin
            pf = 1'b1;
        end else if (level && (pte.ppn[VPN_W-1:0] != '0)) begin
            pf = 1'b1;
        end else begin
            leaf = 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pte.rsw, pte.flags[PTE_D], pte.flags[PTE_G]};

endmodule

// File: rtl/itlb_ptw.sv
// Sv32 page-table walker for ITLB misses. Optional 1-entry L1 PTE cache: ITLB_PTW_L1_CACHE_EN.
module itlb_ptw
    import mms_pkg::*;
#(
    parameter int VADDR_WD = 32,
    parameter int PADDR_WD = 34,
    parameter int ASID_WD  = 9,
    parameter int PTE_WD   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [VADDR_WD-1:0] req_vaddr_i,
    input  logic [ASID_WD-1:0]  req_asid_i,
    input  logic [1:0]          req_mode_i,
    input  logic [21:0]         satp_ppn_i,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [PADDR_WD-1:0] mem_req_addr_o,
    input  logic                mem_rsp_valid_i,
    input  logic [PTE_WD-1:0]   mem_rsp_data_i,
    input  logic                mem_rsp_err_i,
    output logic                refill_valid_o,
    output logic [19:0]         refill_vpn_o,
    output logic [ASID_WD-1:0]  refill_asid_o,
    output logic [PTE_WD-1:0]   refill_pte_o,
    output logic                refill_super_o,
    output logic                fault_valid_o,
    output logic                page_fault_o,
    output logic                access_fault_o
);

    ptw_state_e state, state_nxt;
    logic       kill;

    logic [VPN_W-1:0]   vpn1_q, vpn0_q;
    logic [ASID_WD-1:0] asid_q;
    logic [1:0]         mode_q;
    logic [PPN_W-1:0]   satp_q;
    logic [PPN_W-1:0]   ppn_q;
    pte_t               res_pte;
    logic               res_super, res_pf, res_af;

    va_t  req_va;
    pte_t rsp_pte;
    logic rsp, is_l1, accept;
    logic descend, leaf, pf;
    logic cache_hit;
    logic [PPN_W-1:0] cache_ppn;

    assign req_va  = va_t'(req_vaddr_i);
    assign rsp_pte = pte_t'(mem_rsp_data_i);
    assign is_l1   = (state == ST_L1_WAIT);
    assign rsp     = mem_rsp_valid_i && ((state == ST_L1_WAIT) || (state == ST_L0_WAIT));
    assign accept  = (state == ST_IDLE) && req_valid_i;

    itlb_ptw_pte_check u_check (
        .pte     (rsp_pte),
        .level   (is_l1),
        .mode    (mode_q),
        .descend (descend),
        .leaf    (leaf),
        .pf      (pf)
    );

`ifdef ITLB_PTW_L1_CACHE_EN
    logic               cache_vld;
    logic [ASID_WD-1:0] cache_asid;
    logic [PPN_W-1:0]   cache_satp;
    logic [VPN_W-1:0]   cache_vpn1;

    // A flush in the accept cycle also blocks the hit, so the walk never uses a stale root.
    assign cache_hit = cache_vld && !flush_i && (cache_asid == req_asid_i)
                       && (cache_satp == satp_ppn_i) && (cache_vpn1 == req_va.vpn1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cache_vld  <= 1'b0;
            cache_asid <= '0;
            cache_satp <= '0;
            cache_vpn1 <= '0;
            cache_ppn  <= '0;
        end else if (flush_i) begin
            cache_vld <= 1'b0;
        end else if (rsp && is_l1 && !kill && !mem_rsp_err_i && descend) begin
            cache_vld  <= 1'b1;
            cache_asid <= asid_q;
            cache_satp <= satp_q;
            cache_vpn1 <= vpn1_q;
            cache_ppn  <= rsp_pte.ppn;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_ppn = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            // kill marks an in-flight read whose response must be swallowed.
            case (state)
                ST_L1_REQ, ST_L0_REQ:   kill <= mem_req_ready_i && flush_i;
                ST_L1_WAIT, ST_L0_WAIT: kill <= !mem_rsp_valid_i && (kill || flush_i);
                default:                kill <= 1'b0;
            endcase
        end
    end

    always_comb begin
        state_nxt       = state;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_addr_o  = '0;
        refill_valid_o  = 1'b0;
        fault_valid_o   = 1'b0;
        page_fault_o    = 1'b0;
        access_fault_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_nxt = cache_hit ? ST_L0_REQ : ST_L1_REQ;
            end
            ST_L1_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = PADDR_WD'({satp_q, vpn1_q, 2'b00});
                if (mem_req_ready_i) state_nxt = ST_L1_WAIT;
                else if (flush_i)    state_nxt = ST_IDLE;
            end
            ST_L0_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = PADDR_WD'({ppn_q, vpn0_q, 2'b00});
                if (mem_req_ready_i) state_nxt = ST_L0_WAIT;
                else if (flush_i)    state_nxt = ST_IDLE;
            end
            ST_L1_WAIT: begin
                if (mem_rsp_valid_i) begin
                    if (kill || flush_i)              state_nxt = ST_IDLE;
                    else if (!mem_rsp_err_i && descend) state_nxt = ST_L0_REQ;
                    else                              state_nxt = ST_RESP;
                end
            end
            ST_L0_WAIT: begin
                if (mem_rsp_valid_i) state_nxt = (kill || flush_i) ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                state_nxt      = ST_IDLE;
                refill_valid_o = !flush_i && !(res_pf || res_af);
                fault_valid_o  = !flush_i && (res_pf || res_af);
                page_fault_o   = !flush_i && res_pf;
                access_fault_o = !flush_i && res_af;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vpn1_q    <= '0;
            vpn0_q    <= '0;
            asid_q    <= '0;
            mode_q    <= '0;
            satp_q    <= '0;
            ppn_q     <= '0;
            res_pte   <= '0;
            res_super <= 1'b0;
            res_pf    <= 1'b0;
            res_af    <= 1'b0;
        end else begin
            if (accept) begin
                vpn1_q <= req_va.vpn1;
                vpn0_q <= req_va.vpn0;
                asid_q <= req_asid_i;
                mode_q <= req_mode_i;
                satp_q <= satp_ppn_i;
                if (cache_hit) ppn_q <= cache_ppn;
            end
            if (rsp) begin
                res_pte   <= rsp_pte;
                res_super <= is_l1;
                res_af    <= mem_rsp_err_i;
                res_pf    <= !mem_rsp_err_i && pf;
                if (is_l1 && descend) ppn_q <= rsp_pte.ppn;
            end
        end
    end

    assign refill_vpn_o   = {vpn1_q, vpn0_q};
    assign refill_asid_o  = asid_q;
    assign refill_pte_o   = PTE_WD'(res_pte);
    assign refill_super_o = res_super;

    logic unused_bits;
    assign unused_bits = ^{req_va.offset, leaf};

endmodule

// File: tb/tb_itlb_ptw.sv
// Directed bench for itlb_ptw: walks, fault classes, flush/kill, reset and optional L1 cache.
module tb_itlb_ptw;
    import mms_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic [8:0]  req_asid;
    logic [1:0]  req_mode;
    logic [21:0] satp_ppn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [33:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        refill_valid;
    logic [19:0] refill_vpn;
    logic [8:0]  refill_asid;
    logic [31:0] refill_pte;
    logic        refill_super;
    logic        fault_valid;
    logic        page_fault;
    logic        access_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    itlb_ptw dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_vaddr_i     (req_vaddr),
        .req_asid_i      (req_asid),
        .req_mode_i      (req_mode),
        .satp_ppn_i      (satp_ppn),
        .mem_req_valid_o (mem_req_valid),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_addr_o  (mem_req_addr),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .mem_rsp_err_i   (mem_rsp_err),
        .refill_valid_o  (refill_valid),
        .refill_vpn_o    (refill_vpn),
        .refill_asid_o   (refill_asid),
        .refill_pte_o    (refill_pte),
        .refill_super_o  (refill_super),
        .fault_valid_o   (fault_valid),
        .page_fault_o    (page_fault),
        .access_fault_o  (access_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One walk with ready=1 memory answering the cycle after each accepted read.
    task automatic walk(input string tag, input logic [31:0] va, input logic [1:0] md, input bit fl_acc,
                        input bit do_l1, input logic [33:0] l1_addr, input logic [31:0] l1_pte, input bit l1_err,
                        input bit do_l0, input logic [33:0] l0_addr, input logic [31:0] l0_pte, input bit l0_err,
                        input bit fl_resp, input bit exp_ref, input bit exp_pf, input bit exp_af, input bit exp_sup);
        chk({tag, ".idle_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_vaddr = va;
        req_mode  = md;
        flush     = fl_acc;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        if (do_l1) begin
            chk({tag, ".l1_req"}, mem_req_valid, 1'b1);
            chk({tag, ".l1_addr"}, mem_req_addr, l1_addr);
            @(negedge clk);
            chk({tag, ".l1_wait_bus"}, mem_req_valid, 1'b0);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = l1_pte;
            mem_rsp_err   = l1_err;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
        end
        if (do_l0) begin
            chk({tag, ".l0_req"}, mem_req_valid, 1'b1);
            chk({tag, ".l0_addr"}, mem_req_addr, l0_addr);
            @(negedge clk);
            chk({tag, ".l0_wait_bus"}, mem_req_valid, 1'b0);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = l0_pte;
            mem_rsp_err   = l0_err;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
        end
        if (fl_resp) begin
            flush = 1'b1;
            #1;
        end
        chk({tag, ".refill"}, refill_valid, exp_ref);
        chk({tag, ".fault"}, fault_valid, exp_pf | exp_af);
        chk({tag, ".pf"}, page_fault, exp_pf);
        chk({tag, ".af"}, access_fault, exp_af);
        chk({tag, ".resp_bus"}, mem_req_valid, 1'b0);
        chk({tag, ".resp_busy"}, req_ready, 1'b0);
        if (exp_ref) begin
            chk({tag, ".vpn"}, refill_vpn, va[31:12]);
            chk({tag, ".asid"}, refill_asid, 9'd5);
            chk({tag, ".pte"}, refill_pte, do_l0 ? l0_pte : l1_pte);
            chk({tag, ".super"}, refill_super, exp_sup);
        end
        @(negedge clk);
        flush = 1'b0;
        chk({tag, ".post_refill"}, refill_valid, 1'b0);
        chk({tag, ".post_fault"}, fault_valid, 1'b0);
        chk({tag, ".post_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        req_valid     = 1'b0;
        req_vaddr     = '0;
        req_asid      = 9'd5;
        req_mode      = MODE_S;
        satp_ppn      = 22'h80;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst.ready", req_ready, 1'b1);
        chk("rst.mem_valid", mem_req_valid, 1'b0);
        chk("rst.mem_addr", mem_req_addr, 34'h0);
        chk("rst.refill", refill_valid, 1'b0);
        chk("rst.fault", fault_valid, 1'b0);
        chk("rst.pf", page_fault, 1'b0);
        chk("rst.af", access_fault, 1'b0);
        chk("rst.vpn", refill_vpn, 20'h0);
        chk("rst.pte", refill_pte, 32'h0);
        chk("rst.super", refill_super, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        walk("t1", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 1, 0, 0, 0);
        walk("t2_misaligned", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0000_044B, 0,
             0, 34'h0, 32'h0, 0, 0, 0, 1, 0, 0);
        walk("t3_nox", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_1447, 0, 0, 0, 1, 0, 0);
        walk("t3_u_nou", 32'h0040_1123, MODE_U, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 0, 1, 0, 0);
        walk("t3_u_ok", 32'h0040_1123, MODE_U, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_145B, 0, 0, 1, 0, 0, 0);
        walk("t3_s_upage", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_145B, 0, 0, 0, 1, 0, 0);
        walk("t3_l0_nonleaf", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h0002_0401, 0, 0, 0, 1, 0, 0);
        walk("t4_l0_err", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 1, 0, 0, 0, 1, 0);
        walk("t4_l1_err", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 1,
             0, 34'h0, 32'h0, 0, 0, 0, 0, 1, 0);
        walk("invalid_l1", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0000_0000, 0,
             0, 34'h0, 32'h0, 0, 0, 0, 1, 0, 0);
        walk("w_no_r", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0405, 0,
             0, 34'h0, 32'h0, 0, 0, 0, 1, 0, 0);
        walk("super", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h2000_004B, 0,
             0, 34'h0, 32'h0, 0, 0, 1, 0, 0, 1);
        walk("flush_resp", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h2000_004B, 0,
             0, 34'h0, 32'h0, 0, 1, 0, 0, 0, 0);

        // t5: flush while the L1 read is outstanding; response arrives 3 cycles later.
        chk("t5.ready", req_ready, 1'b1);
        req_valid = 1'b1;
        req_vaddr = 32'h0040_1123;
        req_mode  = MODE_S;
        flush     = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("t5.l1_req", mem_req_valid, 1'b1);
        @(negedge clk);
        chk("t5.l1_wait", mem_req_valid, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t5.drain_ready", req_ready, 1'b0);
            chk("t5.drain_refill", refill_valid, 1'b0);
            chk("t5.drain_fault", fault_valid, 1'b0);
            chk("t5.drain_bus", mem_req_valid, 1'b0);
            @(negedge clk);
        end
        chk("t5.rsp_ready", req_ready, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0002_0401;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t5.after_ready", req_ready, 1'b1);
            chk("t5.after_refill", refill_valid, 1'b0);
            chk("t5.after_fault", fault_valid, 1'b0);
            chk("t5.after_bus", mem_req_valid, 1'b0);
            @(negedge clk);
        end

        // Flush while the L1 request is stalled by the memory side.
        req_valid = 1'b1;
        req_vaddr = 32'h0080_0000;
        flush     = 1'b1;
        @(negedge clk);
        req_valid     = 1'b0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        chk("stall.req", mem_req_valid, 1'b1);
        chk("stall.addr", mem_req_addr, 34'h0_0008_0008);
        @(negedge clk);
        chk("stall.hold_req", mem_req_valid, 1'b1);
        chk("stall.hold_addr", mem_req_addr, 34'h0_0008_0008);
        flush = 1'b1;
        @(negedge clk);
        flush         = 1'b0;
        mem_req_ready = 1'b1;
        chk("stall.flush_ready", req_ready, 1'b1);
        chk("stall.flush_bus", mem_req_valid, 1'b0);
        @(negedge clk);

`ifdef ITLB_PTW_L1_CACHE_EN
        walk("t6_fill", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 1, 0, 0, 0);
        walk("t6_hit", 32'h0040_1123, MODE_S, 0, 0, 34'h0, 32'h0, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 1, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t6.idle_flush_ready", req_ready, 1'b1);
        walk("t6_after_flush", 32'h0040_1123, MODE_S, 0, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 1, 0, 0, 0);
`else
        walk("t6_first", 32'h0040_1123, MODE_S, 1, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 1, 0, 0, 0);
        walk("t6_second", 32'h0040_1123, MODE_S, 0, 1, 34'h0_0008_0004, 32'h0002_0401, 0,
             1, 34'h0_0008_1004, 32'h048D_144B, 0, 0, 1, 0, 0, 0);
`endif

        // Reset in the middle of a walk drops it and clears captured state.
        req_valid = 1'b1;
        req_vaddr = 32'h0040_1123;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.ready", req_ready, 1'b1);
        chk("rst_mid.bus", mem_req_valid, 1'b0);
        chk("rst_mid.vpn", refill_vpn, 20'h0);
        chk("rst_mid.asid", refill_asid, 9'h0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
